// File: rtl/posit_alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational posit ALU.
// Operands are held in registers while the ALU settles; results return tagged.
`timescale 1ns/1ps
module posit_alu_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic       resp_id,
  output logic       resp_err,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_last_q, rr_last_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [2:0]    alu_sel_q, alu_sel_d;
  logic [7:0]    resp_data_q, resp_data_d;
  logic          resp_id_q, resp_id_d;
  logic          resp_err_q, resp_err_d;

  logic       any_req;
  logic       gnt_id;
  logic       idle;
  logic [2:0] sel_in;

  // On a tie the requester that did not win last time gets the grant.
  assign any_req = req0_valid | req1_valid;
  assign gnt_id  = (req0_valid & req1_valid) ? ~rr_last_q
                                             : req1_valid;
  assign idle    = (state_q == IDLE);
  assign sel_in  = gnt_id ? req1_sel : req0_sel;

  assign req0_ready = rst_n & idle & ~gnt_id & req0_valid;
  assign req1_ready = rst_n & idle &  gnt_id & req1_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_last_d   = rr_last_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          alu_a_d   = gnt_id ? req1_a : req0_a;
          alu_b_d   = gnt_id ? req1_b : req0_b;
          alu_sel_d = sel_in;
          resp_id_d = gnt_id;
          rr_last_d = gnt_id;
          cnt_d     = '0;
          if (sel_in <= 3'b100) begin
            state_d = SETTLE;
          end else begin
            resp_data_d = 8'h00;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          resp_data_d = alu_result;
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_last_q   <= 1'b1;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= 3'b000;
      resp_data_q <= 8'h00;
      resp_id_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_posit_alu_arbiter.sv
// Directed bench for posit_alu_arbiter: reset, single op, fairness,
// illegal select, backpressure and a 4-cycle settle instance.
`timescale 1ns/1ps
module tb_posit_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00;
  logic [7:0] req1_a = 8'h00, req1_b = 8'h00;
  logic [2:0] req0_sel = 3'b000, req1_sel = 3'b000;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       resp_valid, resp_id, resp_err, busy;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;

  logic       stub_fixed = 1'b1;
  logic [7:0] stub_val = 8'h00;

  logic       v4 = 1'b0;
  logic [7:0] a4 = 8'h00, b4 = 8'h00;
  logic [2:0] sel4 = 3'b000;
  logic       z1 = 1'b0;
  logic [7:0] z8 = 8'h00;
  logic [2:0] z3 = 3'b000;
  logic [7:0] alu_result4 = 8'h00;
  logic       resp_ready4 = 1'b0;
  logic       r0_ready4, r1_ready4;
  logic [7:0] alu_a4, alu_b4;
  logic [2:0] alu_sel4;
  logic       resp_valid4, resp_id4, resp_err4, busy4;
  logic [7:0] resp_data4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_result = stub_fixed ? stub_val : (alu_a + alu_b);
  end

  posit_alu_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err), .busy(busy)
  );

  posit_alu_arbiter #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v4), .req0_ready(r0_ready4),
    .req0_a(a4), .req0_b(b4), .req0_sel(sel4),
    .req1_valid(z1), .req1_ready(r1_ready4),
    .req1_a(z8), .req1_b(z8), .req1_sel(z3),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4),
    .alu_result(alu_result4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_data(resp_data4), .resp_id(resp_id4),
    .resp_err(resp_err4), .busy(busy4)
  );

  task automatic test_reset();
    logic [31:0] outs;
    @(negedge clk);
    outs = {req0_ready, req1_ready, alu_a, alu_b, alu_sel,
            resp_valid, resp_data, resp_id, resp_err, busy};
    checks++;
    if (outs !== 32'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h want=0", outs);
    end
    rst_n = 1'b1;
    // start an op, then reset in the middle of SETTLE
    stub_fixed = 1'b1; stub_val = 8'h33;
    req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h22;
    req0_sel = 3'b010;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy got=%b want=1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {req0_ready, req1_ready, alu_a, alu_b, alu_sel,
            resp_valid, resp_data, resp_id, resp_err, busy};
    checks++;
    if (outs !== 32'h0) begin
      failures++;
      $display("FAIL reset_async got=%h want=0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_resp v=%b busy=%b want=0,0",
                 resp_valid, busy);
      end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_tie got=%b%b want=10",
               req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_fairness();
    logic       exp_id;
    logic [7:0] exp_d;
    bit         found;
    stub_fixed = 1'b0;
    resp_ready = 1'b1;
    req0_a = 8'h01; req0_b = 8'h02; req0_sel = 3'b011;
    req1_a = 8'h03; req1_b = 8'h04; req1_sel = 3'b100;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = i[0];
      exp_d  = exp_id ? 8'h07 : 8'h03;
      found  = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL fair_timeout idx=%0d got=none want=resp", i);
      end else if (resp_id !== exp_id || resp_data !== exp_d ||
                   resp_err !== 1'b0) begin
        failures++;
        $display("FAIL fair_resp idx=%0d got=%b/%h/%b want=%b/%h/0",
                 i, resp_id, resp_data, resp_err, exp_id, exp_d);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_single_op();
    stub_fixed = 1'b1; stub_val = 8'h50;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h40;
    req0_sel = 3'b000;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b want=1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_sel} !== {8'h40, 8'h40, 3'b000} ||
        busy !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_alu got=%h/%h/%b b=%b v=%b want=40/40/000 1 0",
               alu_a, alu_b, alu_sel, busy, resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got=%b want=0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !==
        {1'b1, 8'h50, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_resp got=%b/%h/%b/%b want=1/50/0/0",
               resp_valid, resp_data, resp_id, resp_err);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done v=%b busy=%b want=0,0",
               resp_valid, busy);
    end
  endtask

  task automatic test_illegal_backpressure();
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h09;
    req1_sel = 3'b110;
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !==
        {1'b1, 8'h00, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL illegal_resp got=%b/%h/%b/%b want=1/00/1/1",
               resp_valid, resp_data, resp_id, resp_err);
    end
    req0_valid = 1'b1; req0_a = 8'h55; req0_sel = 3'b001;
    req1_a = 8'h66; req1_sel = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_data, resp_id, resp_err} !==
          {1'b1, 8'h00, 1'b1, 1'b1} ||
          {req0_ready, req1_ready} !== 2'b00 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%b/%h/%b/%b rdy=%b%b want=1/00/1/1 rdy=00",
                 i, resp_valid, resp_data, resp_id, resp_err,
                 req0_ready, req1_ready);
      end
    end
    resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release v=%b busy=%b want=0,0",
               resp_valid, busy);
    end
  endtask

  task automatic test_settle4();
    v4 = 1'b1; a4 = 8'h12; b4 = 8'h34; sel4 = 3'b010;
    alu_result4 = 8'h11;
    @(negedge clk);
    v4 = 1'b0;
    checks++;
    if ({alu_a4, alu_b4, alu_sel4} !== {8'h12, 8'h34, 3'b010}) begin
      failures++;
      $display("FAIL s4_alu got=%h/%h/%b want=12/34/010",
               alu_a4, alu_b4, alu_sel4);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid4 !== 1'b0) begin
        failures++;
        $display("FAIL s4_early edge=%0d got=%b want=0", i, resp_valid4);
      end
      if (i == 3) alu_result4 = 8'h7E;
    end
    @(negedge clk);
    checks++;
    if ({resp_valid4, resp_data4, resp_id4, resp_err4} !==
        {1'b1, 8'h7E, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL s4_resp got=%b/%h/%b/%b want=1/7e/0/0",
               resp_valid4, resp_data4, resp_id4, resp_err4);
    end
    resp_ready4 = 1'b1;
    @(negedge clk);
    resp_ready4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_op();
    test_illegal_backpressure();
    test_settle4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
